// File: rtl/oclib_pkg.sv
// Shared byte-channel (BC) types and constants for the oclib BC tree.
// Holds the bidirectional channel struct, the framing limit and the combiner state type.
package oclib_pkg;

  localparam logic [7:0] BcLengthMax = 8'd120;

  typedef struct packed {
    logic [7:0] data;
    logic       valid;
    logic       ready;
  } bc_8b_bidi_s;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLock = 2'd1,
    StCopy = 2'd2
  } combinerState_e;

  // A length byte of zero or above the framing limit is a complete 1-byte message.
  function automatic logic bcIsSingleByte(input logic [7:0] len);
    return (len == 8'd0) || (len > BcLengthMax);
  endfunction

endpackage

// File: rtl/oclib_arb_rr.sv
// Combinational round-robin arbiter: first active request at or after the pointer wins.
// Returns both the winning index and a one-hot grant; the caller registers the result.
module oclib_arb_rr #(
  parameter int Inputs = 8
) (
  input  logic [Inputs-1:0]         i_request,
  input  logic [$clog2(Inputs)-1:0] i_pointer,
  output logic                      o_valid,
  output logic [$clog2(Inputs)-1:0] o_index,
  output logic [Inputs-1:0]         o_grant
);

  localparam int IdxW = $clog2(Inputs);

  logic [IdxW:0] w_sum;

  always_comb begin
    o_valid = 1'b0;
    o_index = '0;
    o_grant = '0;
    w_sum   = '0;
    for (int i = 0; i < Inputs; i++) begin
      w_sum = {1'b0, i_pointer} + (IdxW+1)'(i);
      if (w_sum >= (IdxW+1)'(Inputs)) w_sum = w_sum - (IdxW+1)'(Inputs);
      if (!o_valid && i_request[w_sum[IdxW-1:0]]) begin
        o_valid                  = 1'b1;
        o_index                  = w_sum[IdxW-1:0];
        o_grant[w_sum[IdxW-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/oclib_bc_tree_combiner.sv
// Merges child BC response streams into one parent stream, arbitrating per length-framed message.
// Optional stall watchdog enabled by defining OCLIB_BC_COMBINER_TIMEOUT_EN.
module oclib_bc_tree_combiner
  import oclib_pkg::*;
#(
  parameter type BcType        = oclib_pkg::bc_8b_bidi_s,
  parameter int  Inputs        = 8,
  parameter int  TimeoutCycles = 1024
) (
  input  logic  clock,
  input  logic  reset,
  input  BcType downIn  [Inputs],
  output BcType downOut [Inputs],
  output BcType upOut,
  input  BcType upIn,
  output logic  timeoutError
);

  localparam int IdxW = $clog2(Inputs);

  combinerState_e    r_state, w_nextState;
  logic [IdxW-1:0]   r_grant, r_pointer, w_arbIndex, w_nextPointer;
  logic [Inputs-1:0] r_grantOneHot, w_arbOneHot, w_requests;
  logic              w_arbValid;
  logic [7:0]        r_length, r_counter, r_upData;
  logic              r_upValid, r_timeoutError;
  logic              w_selValid;
  logic [7:0]        w_selData;
  logic              w_upRoom, w_accept, w_lastByte, w_timeout;
  logic              w_unusedBits;

  always_comb begin
    w_unusedBits = ^upIn;
    for (int i = 0; i < Inputs; i++) begin
      w_requests[i] = downIn[i].valid;
      w_unusedBits  = w_unusedBits ^ downIn[i].ready;
    end
  end

  oclib_arb_rr #(.Inputs(Inputs)) u_arb (
    .i_request (w_requests),
    .i_pointer (r_pointer),
    .o_valid   (w_arbValid),
    .o_index   (w_arbIndex),
    .o_grant   (w_arbOneHot)
  );

  assign w_selValid    = downIn[r_grant].valid;
  assign w_selData     = downIn[r_grant].data;
  assign w_upRoom      = !r_upValid || upIn.ready;
  assign w_accept      = (r_state != StIdle) && w_selValid && w_upRoom;
  assign w_lastByte    = (r_state == StCopy) && w_accept && (r_counter == r_length - 8'd1);
  assign w_nextPointer = (r_grant == IdxW'(Inputs - 1)) ? '0 : r_grant + IdxW'(1);

`ifdef OCLIB_BC_COMBINER_TIMEOUT_EN
  logic [15:0] r_stall;

  always_ff @(posedge clock) begin
    if (!reset || r_state == StIdle || w_accept) r_stall <= '0;
    else                                         r_stall <= r_stall + 16'd1;
  end

  assign w_timeout = (r_state != StIdle) && !w_accept && (r_stall == 16'(TimeoutCycles - 1));
`else
  localparam int unusedTimeoutCycles = TimeoutCycles;
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) r_state <= StIdle;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      StIdle: if (w_arbValid) w_nextState = StLock;
      StLock: begin
        if (w_timeout)     w_nextState = StIdle;
        else if (w_accept) w_nextState = bcIsSingleByte(w_selData) ? StIdle : StCopy;
      end
      StCopy: if (w_timeout || w_lastByte) w_nextState = StIdle;
      default: w_nextState = StIdle;
    endcase
  end

  // The one-entry output register frees up whenever the parent takes the byte it holds.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_grant        <= '0;
      r_grantOneHot  <= '0;
      r_pointer      <= '0;
      r_length       <= '0;
      r_counter      <= '0;
      r_upValid      <= 1'b0;
      r_upData       <= '0;
      r_timeoutError <= 1'b0;
    end else begin
      r_timeoutError <= w_timeout;
      if (r_state == StIdle && w_arbValid) begin
        r_grant       <= w_arbIndex;
        r_grantOneHot <= w_arbOneHot;
        r_counter     <= '0;
      end
      if (r_state == StLock && w_accept) begin
        r_length  <= w_selData;
        r_counter <= '0;
      end
      if (r_state == StCopy && w_accept) r_counter <= r_counter + 8'd1;
      if (w_lastByte || w_timeout) r_pointer <= w_nextPointer;
      if (w_accept) begin
        r_upValid <= 1'b1;
        r_upData  <= w_selData;
      end else if (upIn.ready) begin
        r_upValid <= 1'b0;
      end
    end
  end

  always_comb begin
    upOut        = '0;
    upOut.valid  = r_upValid;
    upOut.data   = r_upData;
    timeoutError = r_timeoutError;
    for (int i = 0; i < Inputs; i++) begin
      downOut[i]       = '0;
      downOut[i].ready = r_grantOneHot[i] && (r_state != StIdle) && w_upRoom;
    end
  end

endmodule

// File: tb/tb_oclib_bc_tree_combiner.sv
// Directed testbench for oclib_bc_tree_combiner with a byte scoreboard that also checks
// the number of cycles between consecutive parent-side bytes.
module tb_oclib_bc_tree_combiner;
  import oclib_pkg::*;

  localparam int Inputs        = 8;
  localparam int TimeoutCycles = 16;
  localparam int MemDepth      = 256;

  typedef struct {
    logic [7:0] data;
    int         gap;
  } expEntry_t;

  logic        clock = 1'b0;
  logic        reset;
  bc_8b_bidi_s downIn  [Inputs];
  bc_8b_bidi_s downOut [Inputs];
  bc_8b_bidi_s upOut;
  bc_8b_bidi_s upIn;
  logic        timeoutError;

  logic [7:0]  childMem  [Inputs][MemDepth];
  int          childHead [Inputs];
  int          childTail [Inputs];
  logic        childFire [Inputs];
  logic        flushReq;
  logic        sbEnable;
  expEntry_t   expQ[$];

  int          testsRun = 0;
  int          testsFailed = 0;
  int          cycleCount = 0;
  int          lastOutCycle = 0;
  int          pulseCount = 0;
  int          pulseGap = 0;
  logic        holdPending = 1'b0;
  logic [7:0]  heldData = '0;

  oclib_bc_tree_combiner #(
    .BcType        (bc_8b_bidi_s),
    .Inputs        (Inputs),
    .TimeoutCycles (TimeoutCycles)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .downIn       (downIn),
    .downOut      (downOut),
    .upOut        (upOut),
    .upIn         (upIn),
    .timeoutError (timeoutError)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycleCount <= cycleCount + 1;

  // Each child presents the head of its byte list whenever the list is non-empty.
  always_comb begin
    for (int i = 0; i < Inputs; i++) begin
      downIn[i] = '0;
      if (childHead[i] < childTail[i]) begin
        downIn[i].valid = 1'b1;
        downIn[i].data  = childMem[i][childHead[i]];
      end
    end
  end

  // Children advance one byte after every handshake seen at the preceding falling edge.
  always @(posedge clock) begin
    #1;
    for (int i = 0; i < Inputs; i++) begin
      if (childFire[i] && childHead[i] < childTail[i]) childHead[i] = childHead[i] + 1;
      if (flushReq) childHead[i] = childTail[i];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Parent-side monitor: scoreboard pop, hold stability and timeout pulse bookkeeping.
  always @(negedge clock) begin
    for (int i = 0; i < Inputs; i++) childFire[i] = downIn[i].valid && downOut[i].ready;
    if (!sbEnable) begin
      holdPending = 1'b0;
    end else begin
      if (holdPending) begin
        checkOutput("hold_valid", upOut.valid, 1);
        checkOutput("hold_data", upOut.data, heldData);
      end
      holdPending = upOut.valid && !upIn.ready;
      heldData    = upOut.data;
      if (timeoutError) begin
        pulseCount++;
        pulseGap = cycleCount - lastOutCycle;
      end
      if (upOut.valid && upIn.ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_byte", 32'(expQ.size()), 1);
        end else begin
          expEntry_t e;
          e = expQ.pop_front();
          checkOutput("data", upOut.data, e.data);
          if (e.gap != 0) checkOutput("gap", cycleCount - lastOutCycle, e.gap);
        end
        lastOutCycle = cycleCount;
      end
    end
  end

  task automatic applyStimulus(input int child, input logic [7:0] data, input int gap);
    expEntry_t e;
    childMem[child][childTail[child]] = data;
    childTail[child] = childTail[child] + 1;
    e.data = data;
    e.gap  = gap;
    expQ.push_back(e);
  endtask

  task automatic sendPattern(input int child, input int len, input logic [7:0] base,
                             input int firstGap, input int restGap);
    applyStimulus(child, 8'(len), firstGap);
    for (int k = 0; k < len; k++) applyStimulus(child, 8'(base + k), restGap);
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic checkIdle(input string tag);
    logic [31:0] downBits;
    downBits = '0;
    for (int i = 0; i < Inputs; i++) downBits = downBits | 32'(downOut[i]);
    checkOutput({tag, "_downOut"}, downBits, 0);
    checkOutput({tag, "_upValid"}, upOut.valid, 0);
  endtask

  task automatic waitDrain(input string tag, input int budget);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checkOutput({tag, "_drained"}, 32'(expQ.size()), 0);
    tick();
    checkIdle(tag);
  endtask

  task automatic pulseReset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int pulsesBefore;
    reset    = 1'b0;
    upIn     = '0;
    upIn.ready = 1'b1;
    sbEnable = 1'b1;
    flushReq = 1'b0;
    repeat (3) tick();
    checkIdle("reset");
    checkOutput("reset_upOut", 32'(upOut), 0);
    checkOutput("reset_timeoutError", timeoutError, 0);
    reset = 1'b1;

    // Single message from child 2, streamed back-to-back with one cycle latency.
    applyStimulus(2, 8'h05, 0);
    applyStimulus(2, 8'h00, 1);
    applyStimulus(2, 8'h00, 1);
    applyStimulus(2, 8'h00, 1);
    applyStimulus(2, 8'h02, 1);
    applyStimulus(2, 8'hAA, 1);
    waitDrain("t1", 50);

    // Simultaneous children 0 and 3 from pointer 0; then 2 and 5 prove the pointer sits at 4.
    pulseReset();
    sendPattern(0, 4, 8'h10, 0, 1);
    sendPattern(3, 4, 8'h30, 2, 1);
    waitDrain("t2", 60);
    sendPattern(5, 3, 8'h50, 0, 1);
    sendPattern(2, 3, 8'h20, 2, 1);
    waitDrain("t2_pointer", 60);

    // Parent backpressure toggled during an L=10 message.
    sendPattern(4, 10, 8'h40, 0, 0);
    for (int k = 0; k < 60; k++) begin
      tick();
      upIn.ready = (k % 4 == 3) ? 1'b1 : 1'($urandom_range(0, 1));
    end
    tick();
    upIn.ready = 1'b1;
    waitDrain("t3", 60);

    // Sync token then a normal message: arbitration bubble between them.
    applyStimulus(1, 8'h7E, 0);
    sendPattern(1, 4, 8'h60, 2, 1);
    waitDrain("t4", 60);

    // Length boundaries: 0 and 121 are lone bytes, 120 is a full message.
    applyStimulus(7, 8'h00, 0);
    applyStimulus(7, 8'h79, 2);
    sendPattern(7, 120, 8'h80, 2, 1);
    sendPattern(7, 1, 8'h55, 2, 1);
    waitDrain("t4_bounds", 300);

    // Reset in the middle of a message, then a fresh message from child 0.
    sendPattern(0, 6, 8'hC0, 0, 1);
    n = 0;
    while (expQ.size() > 4 && n < 40) begin
      tick();
      n++;
    end
    checkOutput("t5_progress", 32'(expQ.size() <= 4), 1);
    reset    = 1'b0;
    sbEnable = 1'b0;
    flushReq = 1'b1;
    expQ.delete();
    tick();
    checkIdle("t5_reset");
    checkOutput("t5_upOut", 32'(upOut), 0);
    checkOutput("t5_timeoutError", timeoutError, 0);
    reset    = 1'b1;
    flushReq = 1'b0;
    sbEnable = 1'b1;
    sendPattern(0, 5, 8'hD0, 0, 1);
    waitDrain("t5", 60);

`ifdef OCLIB_BC_COMBINER_TIMEOUT_EN
    // Child 5 stalls after 3 of 9 bytes; the registered pulse follows the 16th stall cycle.
    pulseReset();
    pulsesBefore = pulseCount;
    applyStimulus(5, 8'h08, 0);
    applyStimulus(5, 8'h01, 1);
    applyStimulus(5, 8'h02, 1);
    sendPattern(6, 3, 8'h6A, 18, 1);
    waitDrain("t6", 80);
    checkOutput("t6_pulses", pulseCount - pulsesBefore, 1);
    checkOutput("t6_pulseGap", pulseGap, 16);
`else
    pulsesBefore = 0;
    checkOutput("no_timeout_pulses", pulseCount, pulsesBefore);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
